// File: rtl/gate_bist_checker_if.sv
// Bus between the BIST checker and its controlling environment / gate under test.
// The slave side is the checker: it takes start and the gate output, and drives
// the vector plus the run status and results.
interface gate_bist_checker_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] vec_out;
    logic            dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] fail_vec;

    modport master (
        output start,
        output dut_in,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec
    );

    modport slave (
        input  start,
        input  dut_in,
        output vec_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec
    );
endinterface

// File: rtl/gate_bist_checker.sv
// Sequential BIST engine for small combinational gates. Steps every input
// vector in ascending order, waits SETTLE cycles, samples the gate output for
// one CHECK cycle and compares it with the golden TRUTH table. Reports pass,
// mismatch count and first failing vector.
// Optional feature macro: BIST_STOP_ON_FAIL_EN -- when defined the run ends on
// the first mismatch, leaving vec_out on the failing vector.
module gate_bist_checker #(
    parameter int                      N_IN   = 2,
    parameter int                      SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b0001
) (
    input  logic               clk,
    input  logic               rst,
    gate_bist_checker_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Counter is wide enough to hold SETTLE-1 even when SETTLE is 1.
    localparam int              CNT_W    = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]    ERR_ONE  = (N_IN + 1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [N_IN-1:0]   vec;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   fail_vec;

    logic              mismatch;
    logic              settled;
    logic              last_vec;
    logic              accept;

    assign mismatch = (bus.dut_in != TRUTH[vec]);
    assign settled  = (cnt == CNT_LAST);
    assign last_vec = &vec;
    assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));

    // State register: reset returns to IDLE regardless of start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start only matters when not busy.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settled) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef BIST_STOP_ON_FAIL_EN
                if (mismatch || last_vec) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SETTLE;
                end
`else
                if (last_vec) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SETTLE;
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: vector stepping, settle timing and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        vec       <= '0;
                        cnt       <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settled) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_CHECK: begin
                    // Count never exceeds 2**N_IN, which fits in N_IN+1 bits.
                    if (mismatch) begin
                        err_count <= err_count + ERR_ONE;
                        if (err_count == '0) begin
                            fail_vec <= vec;
                        end
                    end
`ifdef BIST_STOP_ON_FAIL_EN
                    // Hold the failing vector so the gate stays on it.
                    if (!last_vec && !mismatch) begin
                        vec <= vec + VEC_ONE;
                    end
`else
                    if (!last_vec) begin
                        vec <= vec + VEC_ONE;
                    end
`endif
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Outputs: status flags derive from state; pass reads the final count.
    always_comb begin
        bus.busy      = (state == S_SETTLE) || (state == S_CHECK);
        bus.done      = (state == S_DONE);
        bus.pass      = (state == S_DONE) && (err_count == '0);
        bus.vec_out   = vec;
        bus.err_count = err_count;
        bus.fail_vec  = fail_vec;
    end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Self-checking bench for gate_bist_checker. A modelled gate responds to
// vec_out from a response table; expected results come from a table-level
// reference model of the BIST outcome.
module tb_gate_bist_checker;

    localparam int             N_IN    = 2;
    localparam int             SETTLE  = 2;
    localparam logic [3:0]     TRUTH   = 4'b0001;
    localparam int             NV      = 1 << N_IN;
    localparam int             CPV     = SETTLE + 1;
    localparam int             TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst;
    logic [NV-1:0] resp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gate_bist_checker_if #(.N_IN(N_IN)) bif ();

    // Modelled gate: output for the currently applied vector.
    assign bif.dut_in = resp[bif.vec_out];

    gate_bist_checker #(
        .N_IN  (N_IN),
        .SETTLE(SETTLE),
        .TRUTH (TRUTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    // Reference outcome of a full run against a gate with response table r.
    function automatic void model(input logic [NV-1:0] r, output int e_err,
                                  output int e_fail, output int e_cyc, output int e_vec);
        int first = -1;
        int cnt   = 0;
        for (int v = 0; v < NV; v++) begin
            if (r[v] !== TRUTH[v]) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
        e_fail = (first < 0) ? 0 : first;
`ifdef BIST_STOP_ON_FAIL_EN
        if (cnt > 0) begin
            e_err = 1;
            e_cyc = (first + 1) * CPV;
            e_vec = first;
        end else begin
            e_err = 0;
            e_cyc = NV * CPV;
            e_vec = NV - 1;
        end
`else
        e_err = cnt;
        e_cyc = NV * CPV;
        e_vec = NV - 1;
`endif
    endfunction

    // Pulse start and count edges after the accepting edge until done is seen.
    task automatic run_bist(output int cyc);
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        cyc = 0;
        while (bif.done !== 1'b1 && cyc < TIMEOUT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= TIMEOUT) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.start = 1'b0;
        resp = TRUTH;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bif.vec_out !== '0) $display("FAIL reset_vec_out got=%0h exp=0", bif.vec_out); else n_pass++;
        n_checks++; if (bif.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bif.busy); else n_pass++;
        n_checks++; if (bif.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bif.done); else n_pass++;
        n_checks++; if (bif.pass !== 1'b0) $display("FAIL reset_pass got=%b exp=0", bif.pass); else n_pass++;
        n_checks++; if (bif.err_count !== '0) $display("FAIL reset_err_count got=%0d exp=0", bif.err_count); else n_pass++;
        n_checks++; if (bif.fail_vec !== '0) $display("FAIL reset_fail_vec got=%0h exp=0", bif.fail_vec); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nor_pass();
        logic [N_IN-1:0] e_vec;
        logic            e_busy;
        logic            e_done;
        resp = TRUTH;
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        for (int c = 0; c <= NV * CPV; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            e_vec  = (c < NV * CPV) ? N_IN'(c / CPV) : N_IN'(NV - 1);
            e_busy = (c < NV * CPV);
            e_done = (c == NV * CPV);
            n_checks++; if (bif.vec_out !== e_vec) $display("FAIL nor_vec_out c=%0d got=%0h exp=%0h", c, bif.vec_out, e_vec); else n_pass++;
            n_checks++; if (bif.busy !== e_busy) $display("FAIL nor_busy c=%0d got=%b exp=%b", c, bif.busy, e_busy); else n_pass++;
            n_checks++; if (bif.done !== e_done) $display("FAIL nor_done c=%0d got=%b exp=%b", c, bif.done, e_done); else n_pass++;
        end
        n_checks++; if (bif.pass !== 1'b1) $display("FAIL nor_pass got=%b exp=1", bif.pass); else n_pass++;
        n_checks++; if (bif.err_count !== '0) $display("FAIL nor_err_count got=%0d exp=0", bif.err_count); else n_pass++;
        // Outputs must stay put in DONE.
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (bif.done !== 1'b1 || bif.vec_out !== N_IN'(NV - 1)) $display("FAIL nor_hold done=%b vec=%0h exp done=1 vec=%0h", bif.done, bif.vec_out, NV - 1); else n_pass++;
    endtask

    task automatic test_fault_patterns();
        logic [NV-1:0] pats [3] = '{4'b1110, 4'b0000, 4'b1001};
        int e_err, e_fail, e_cyc, e_vec, cyc;
        for (int i = 0; i < 19; i++) begin
            resp = (i < 3) ? pats[i] : NV'($urandom_range(0, NV - 1 + NV * 3));
            model(resp, e_err, e_fail, e_cyc, e_vec);
            run_bist(cyc);
            n_checks++; if (cyc !== e_cyc) $display("FAIL fault_cycles resp=%b got=%0d exp=%0d", resp, cyc, e_cyc); else n_pass++;
            n_checks++; if (bif.err_count !== (N_IN + 1)'(e_err)) $display("FAIL fault_err_count resp=%b got=%0d exp=%0d", resp, bif.err_count, e_err); else n_pass++;
            n_checks++; if (bif.pass !== (e_err == 0)) $display("FAIL fault_pass resp=%b got=%b exp=%b", resp, bif.pass, e_err == 0); else n_pass++;
            n_checks++; if (bif.vec_out !== N_IN'(e_vec)) $display("FAIL fault_vec_out resp=%b got=%0h exp=%0h", resp, bif.vec_out, e_vec); else n_pass++;
            if (e_err != 0) begin
                n_checks++; if (bif.fail_vec !== N_IN'(e_fail)) $display("FAIL fault_fail_vec resp=%b got=%0h exp=%0h", resp, bif.fail_vec, e_fail); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        // Leave DONE with a nonzero count, then restart with a good gate.
        resp = 4'b1110;
        run_bist(cyc);
        resp = TRUTH;
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        n_checks++; if (bif.done !== 1'b0 || bif.busy !== 1'b1) $display("FAIL b2b_restart_flags done=%b busy=%b exp done=0 busy=1", bif.done, bif.busy); else n_pass++;
        n_checks++; if (bif.vec_out !== '0) $display("FAIL b2b_restart_vec got=%0h exp=0", bif.vec_out); else n_pass++;
        n_checks++; if (bif.err_count !== '0 || bif.pass !== 1'b0) $display("FAIL b2b_restart_clear err=%0d pass=%b exp err=0 pass=0", bif.err_count, bif.pass); else n_pass++;
        cyc = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        // Start pulse while busy, sampled at the 5th edge of the run.
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        bif.start = 1'b0;
        n_checks++; if (bif.vec_out !== N_IN'(1) || bif.busy !== 1'b1) $display("FAIL b2b_ignored_start vec=%0h busy=%b exp vec=1 busy=1", bif.vec_out, bif.busy); else n_pass++;
        while (bif.done !== 1'b1 && cyc < TIMEOUT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++; if (cyc !== NV * CPV) $display("FAIL b2b_cycles got=%0d exp=%0d", cyc, NV * CPV); else n_pass++;
        n_checks++; if (bif.pass !== 1'b1) $display("FAIL b2b_pass got=%b exp=1", bif.pass); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int cyc;
        resp = 4'b1110;
        @(negedge clk);
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        repeat (6) @(posedge clk);
        // rst together with start: reset must win on the 7th edge.
        @(negedge clk);
        rst = 1'b1;
        bif.start = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (bif.busy !== 1'b0 || bif.done !== 1'b0) $display("FAIL midrst_flags busy=%b done=%b exp 0 0", bif.busy, bif.done); else n_pass++;
        n_checks++; if (bif.vec_out !== '0) $display("FAIL midrst_vec got=%0h exp=0", bif.vec_out); else n_pass++;
        n_checks++; if (bif.err_count !== '0 || bif.fail_vec !== '0 || bif.pass !== 1'b0) $display("FAIL midrst_results err=%0d fail=%0h pass=%b exp 0 0 0", bif.err_count, bif.fail_vec, bif.pass); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bif.start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (bif.busy !== 1'b0) $display("FAIL midrst_idle busy=%b exp=0", bif.busy); else n_pass++;
        resp = TRUTH;
        run_bist(cyc);
        n_checks++; if (cyc !== NV * CPV) $display("FAIL midrst_rerun_cycles got=%0d exp=%0d", cyc, NV * CPV); else n_pass++;
        n_checks++; if (bif.pass !== 1'b1 || bif.err_count !== '0) $display("FAIL midrst_rerun_pass pass=%b err=%0d exp 1 0", bif.pass, bif.err_count); else n_pass++;
    endtask

    initial begin
        bif.start = 1'b0;
        rst = 1'b1;
        resp = TRUTH;
        test_reset();
        test_nor_pass();
        test_fault_patterns();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
